// File: rtl/calc_pkg.sv
// calc_pkg: step encodings and loader state type shared with the control unit
package calc_pkg;

    localparam logic [3:0] STEP_A1 = 4'd1;
    localparam logic [3:0] STEP_A2 = 4'd2;
    localparam logic [3:0] STEP_A3 = 4'd3;
    localparam logic [3:0] STEP_A4 = 4'd4;
    localparam logic [3:0] STEP_B1 = 4'd5;
    localparam logic [3:0] STEP_B2 = 4'd6;
    localparam logic [3:0] STEP_B3 = 4'd7;
    localparam logic [3:0] STEP_B4 = 4'd8;
    localparam logic [3:0] STEP_R1 = 4'd9;
    localparam logic [3:0] STEP_R2 = 4'd10;
    localparam logic [3:0] STEP_R3 = 4'd11;
    localparam logic [3:0] STEP_R4 = 4'd12;

    typedef enum logic [1:0] {IDLE, SAMPLE, WRITE, ACK} loader_state_t;

endpackage

// File: rtl/input_sync.sv
// input_sync: two-flop synchronizer for signals asynchronous to clk
module input_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d, sync_q, sync_d;

    // next values simply shift the input down the two-stage chain
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // chain flops, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: debounces the data switches and loads one operand nibble per load handshake
module operand_loader
    import calc_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loaddata,
    input  logic [3:0]        step,
    input  logic [3:0]        sw,
    output logic              inputdata_ready,
    output logic [4*NDIG-1:0] opa,
    output logic [4*NDIG-1:0] opb,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(STABLE_CYCLES);

    logic              load_s;
    logic [3:0]        sw_s;
    loader_state_t     state_q, state_d;
    logic [3:0]        step_q, step_d, snap_q, snap_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] opa_q, opa_d, opb_q, opb_d;
    logic              ready_q, ready_d, busy_q, busy_d, err_q, err_d;
    logic              valid;

    input_sync #(.W(1)) u_load_sync (.clk(clk), .rst(rst), .d(loaddata), .q(load_s));
    input_sync #(.W(4)) u_sw_sync   (.clk(clk), .rst(rst), .d(sw),       .q(sw_s));

    assign valid = step_q >= STEP_A1 && step_q <= 4'(2*NDIG);

    // handshake sequencing, debounce counting and the single-cycle operand write
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            IDLE: if (load_s) begin
                state_d = SAMPLE;
                step_d  = step;
                snap_d  = sw_s;
                cnt_d   = '0;
            end
            SAMPLE: if (!load_s) begin
                state_d = IDLE;
            end else if (sw_s != snap_q) begin
                snap_d = sw_s;
                cnt_d  = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(STABLE_CYCLES-2)) ? WRITE : SAMPLE;
            end
            WRITE: begin
                state_d = ACK;
                for (int i = 0; i < NDIG; i++) begin
                    if (step_q == 4'(i+1))      opa_d[4*(NDIG-1-i) +: 4] = snap_q;
                    if (step_q == 4'(NDIG+i+1)) opb_d[4*(NDIG-1-i) +: 4] = snap_q;
                end
            end
            ACK: state_d = load_s ? ACK : IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = state_d == ACK;
        busy_d  = state_d != IDLE;
        err_d   = state_d == ACK && ((state_q == WRITE) ? !valid : err_q);
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign inputdata_ready = ready_q;
    assign opa             = opa_q;
    assign opb             = opb_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed and randomized load handshakes against a nibble-array operand model
module tb_operand_loader;

    localparam int NDIG = 4;
    localparam int SC   = 4;

    logic        clk = 1'b0;
    logic        rst, loaddata, ready, busy, err;
    logic [3:0]  step, sw;
    logic [15:0] opa, opb;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] ma [4];
    logic [3:0] mb [4];
    logic       merr;

    operand_loader #(.NDIG(NDIG), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .loaddata(loaddata), .step(step), .sw(sw),
        .inputdata_ready(ready), .opa(opa), .opb(opb), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_opa();
        return {ma[0], ma[1], ma[2], ma[3]};
    endfunction

    function automatic logic [15:0] exp_opb();
        return {mb[0], mb[1], mb[2], mb[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ma[i] = 4'h0;
            mb[i] = 4'h0;
        end
        merr = 1'b0;
    endtask

    task automatic model_load(input logic [3:0] st, input logic [3:0] v);
        int s;
        s = int'(st);
        if (s >= 1 && s <= 4)      ma[s-1] = v;
        else if (s >= 5 && s <= 8) mb[s-5] = v;
        merr = !(s >= 1 && s <= 8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_opa"}, opa, 0);
        check({tag, "_opb"}, opb, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic do_load(input logic [3:0] st, input logic [3:0] v);
        int n;
        step = st;
        sw = v;
        loaddata = 1'b1;
        model_load(st, v);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check("ack_seen", ready, 1);
        check("opa", opa, exp_opa());
        check("opb", opb, exp_opb());
        check("err_ack", err, merr);
        check("busy_ack", busy, 1);
        loaddata = 1'b0;
        n = 0;
        while (ready !== 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        check("ready_drop", ready, 0);
        check("err_drop", err, 0);
        check("busy_drop", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        rst = 1'b1;
        loaddata = 1'b0;
        step = 4'h0;
        sw = 4'h0;
        #3 rst = 1'b0;
        repeat (3) begin
            loaddata = 1'($urandom_range(0, 1));
            step = 4'($urandom_range(0, 15));
            sw = 4'($urandom_range(0, 15));
            tick(1);
            check_zero("reset");
        end
        loaddata = 1'b0;
        rst = 1'b1;
        tick(3);

        step = 4'd1;
        sw = 4'hA;
        loaddata = 1'b1;
        model_load(4'd1, 4'hA);
        tick(6);
        check("lat_early", ready, 0);
        tick(1);
        check("lat_ready", ready, 1);
        check("lat_opa", opa, 16'hA000);
        check("lat_err", err, 0);
        loaddata = 1'b0;
        tick(3);
        check("lat_drop", ready, 0);
        check("lat_idle", busy, 0);

        for (int i = 1; i <= 8; i++) do_load(4'(i), 4'(i));
        check("entry_opa", opa, 16'h1234);
        check("entry_opb", opb, 16'h5678);

        step = 4'd5;
        loaddata = 1'b1;
        model_load(4'd5, 4'hB);
        for (int k = 0; k < 10; k++) begin
            sw = (k % 2 == 0) ? 4'hA : 4'hB;
            tick(1);
            check("bounce_ready", ready, 0);
            tick(1);
            check("bounce_ready", ready, 0);
        end
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("bounce_latency", n, 2 + 1 + (SC - 1) + 1 - 2);
        check("bounce_opb", opb, exp_opb());
        check("bounce_opa", opa, exp_opa());
        loaddata = 1'b0;
        tick(3);
        check("bounce_drop", ready, 0);

        step = 4'd2;
        sw = 4'hC;
        loaddata = 1'b1;
        repeat (3) begin
            tick(1);
            check("abort_ready", ready, 0);
        end
        loaddata = 1'b0;
        repeat (6) begin
            tick(1);
            check("abort_ready", ready, 0);
        end
        check("abort_busy", busy, 0);
        check("abort_opa", opa, exp_opa());

        do_load(4'd9, 4'hF);
        do_load(4'd0, 4'hF);

        repeat (12) do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        step = 4'd3;
        sw = 4'h5;
        loaddata = 1'b1;
        tick(4);
        check("mid_sample_busy", busy, 1);
        rst = 1'b0;
        model_reset();
        #1;
        check_zero("rst_sample");
        loaddata = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);

        step = 4'd6;
        sw = 4'h9;
        loaddata = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check("mid_ack_ready", ready, 1);
        rst = 1'b0;
        #1;
        check_zero("rst_ack");
        loaddata = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);

        do_load(4'd4, 4'h7);
        check("post_rst_opa", opa, 16'h0007);
        check("post_rst_opb", opb, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
